// File: rtl/iurt_dwn_buffer.sv
// Byte FIFO from the JTAG hub downstream channel to the IURT controller receive input.
// Emits one byte per controller ready-high phase and tracks fill level and a sticky overflow.
module iurt_dwn_buffer #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  hub_dwn_valid,
  input  logic [7:0]            hub_dwn,
  output logic                  hub_dwn_ready,
  input  logic                  ctrl_dwn_ready,
  output logic                  ctrl_dwn_valid,
  output logic [7:0]            ctrl_dwn,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned            DEPTH       = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]    FULL_COUNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    EMPTY_COUNT = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0]    COUNT_ONE   = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0]  PTR_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]  PTR_ONE     = ADDR_WIDTH'(1'b1);

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  holdoff_q, holdoff_d;
  logic                  valid_q, valid_d;
  logic [7:0]            data_q, data_d;
  logic                  overflow_q, overflow_d;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  drop_s;
  logic                  mem_we_s;

  // Next-state computation for pointers, count, holdoff, output byte and overflow.
  always_comb begin
    full_s    = (count_q == FULL_COUNT);
    empty_s   = (count_q == EMPTY_COUNT);
    // Full check uses the pre-edge count, so a same-cycle emit never frees a slot.
    wr_en_s   = ce & hub_dwn_valid & ~full_s;
    drop_s    = ce & hub_dwn_valid & full_s;
    rd_en_s   = ce & ~empty_s & ctrl_dwn_ready & ~holdoff_q;
    mem_we_s  = wr_en_s & ~rst;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    holdoff_d  = holdoff_q;
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_d = overflow_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      data_d    = mem_q[rd_ptr_q];
      valid_d   = 1'b1;
      holdoff_d = 1'b1;
    end else if (ce) begin
      valid_d   = 1'b0;
      holdoff_d = ctrl_dwn_ready ? holdoff_q : 1'b0;
    end else begin
      valid_d   = valid_q;
      holdoff_d = holdoff_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ce & clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers with synchronous reset overriding ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= EMPTY_COUNT;
      holdoff_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      holdoff_q  <= holdoff_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; deliberately not reset, only written slots are ever read.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= hub_dwn;
    end
  end

  assign hub_dwn_ready  = (count_q != FULL_COUNT);
  assign fill_level     = count_q;
  assign ctrl_dwn_valid = valid_q;
  assign ctrl_dwn       = data_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_iurt_dwn_buffer.sv
// Directed self-checking bench for iurt_dwn_buffer (DEPTH = 16) with a queue scoreboard.
module tb_iurt_dwn_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       hub_dwn_valid = 1'b0;
  logic [7:0] hub_dwn = 8'h00;
  logic       hub_dwn_ready;
  logic       ctrl_dwn_ready = 1'b0;
  logic       ctrl_dwn_valid;
  logic [7:0] ctrl_dwn;
  logic [4:0] fill_level;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  tmp;
  int          rx;
  int          timer;

  iurt_dwn_buffer #(.ADDR_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .hub_dwn_valid  (hub_dwn_valid),
    .hub_dwn        (hub_dwn),
    .hub_dwn_ready  (hub_dwn_ready),
    .ctrl_dwn_ready (ctrl_dwn_ready),
    .ctrl_dwn_valid (ctrl_dwn_valid),
    .ctrl_dwn       (ctrl_dwn),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One hub byte at the next edge; only valid to call while no emit can happen.
  task automatic inject(input logic [7:0] b);
    hub_dwn       = b;
    hub_dwn_valid = 1'b1;
    tick();
    hub_dwn_valid = 1'b0;
    if (exp_q.size() < 16) exp_q.push_back(b);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      ctrl_dwn_ready = 1'b1;
      tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check_eq("drain_valid", {31'd0, ctrl_dwn_valid}, 32'd1);
      check_eq("drain_data", {24'd0, ctrl_dwn}, {24'd0, e});
      ctrl_dwn_ready = 1'b0;
      tick();
      check_eq("drain_gap", {31'd0, ctrl_dwn_valid}, 32'd0);
    end
  endtask

  initial begin
    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_hub_ready", {31'd0, hub_dwn_ready}, 32'd1);
    check_eq("rst_valid", {31'd0, ctrl_dwn_valid}, 32'd0);
    check_eq("rst_fill", {27'd0, fill_level}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_data", {24'd0, ctrl_dwn}, 32'h00);

    // Single byte, 2-cycle latency, holdoff while ready stays high
    ctrl_dwn_ready = 1'b1;
    hub_dwn        = 8'hA5;
    hub_dwn_valid  = 1'b1;
    tick();
    hub_dwn_valid  = 1'b0;
    check_eq("single_fill1", {27'd0, fill_level}, 32'd1);
    check_eq("single_early", {31'd0, ctrl_dwn_valid}, 32'd0);
    tick();
    check_eq("single_valid", {31'd0, ctrl_dwn_valid}, 32'd1);
    check_eq("single_data", {24'd0, ctrl_dwn}, 32'hA5);
    check_eq("single_fill0", {27'd0, fill_level}, 32'd0);
    hub_dwn        = 8'hB6;
    hub_dwn_valid  = 1'b1;
    tick();
    hub_dwn_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("holdoff_no_pulse", {31'd0, ctrl_dwn_valid}, 32'd0);
      check_eq("holdoff_fill", {27'd0, fill_level}, 32'd1);
      check_eq("holdoff_data", {24'd0, ctrl_dwn}, 32'hA5);
      tick();
    end
    ctrl_dwn_ready = 1'b0;
    tick();
    ctrl_dwn_ready = 1'b1;
    tick();
    check_eq("rearm_valid", {31'd0, ctrl_dwn_valid}, 32'd1);
    check_eq("rearm_data", {24'd0, ctrl_dwn}, 32'hB6);
    ctrl_dwn_ready = 1'b0;
    tick();

    // Burst of 01..10 then drain through a controller model
    for (int i = 1; i <= 16; i++) inject(8'(i));
    check_eq("burst_peak", {27'd0, fill_level}, 32'd16);
    check_eq("burst_full", {31'd0, hub_dwn_ready}, 32'd0);
    ctrl_dwn_ready = 1'b1;
    rx    = 0;
    timer = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (ctrl_dwn_valid) begin
        rx++;
        tmp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check_eq("burst_data", {24'd0, ctrl_dwn}, {24'd0, tmp});
        ctrl_dwn_ready = 1'b0;
        timer = 3;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) ctrl_dwn_ready = 1'b1;
      end
    end
    ctrl_dwn_ready = 1'b0;
    tick();
    check_eq("burst_count", rx, 32'd16);
    check_eq("burst_empty", {27'd0, fill_level}, 32'd0);

    // Overflow, set-wins-over-clear, clear, drain
    for (int i = 0; i < 15; i++) inject(8'h20 + 8'(i));
    check_eq("ovf_ready15", {31'd0, hub_dwn_ready}, 32'd1);
    inject(8'h2F);
    check_eq("ovf_ready16", {31'd0, hub_dwn_ready}, 32'd0);
    check_eq("ovf_fill16", {27'd0, fill_level}, 32'd16);
    check_eq("ovf_not_yet", {31'd0, overflow}, 32'd0);
    inject(8'hEE);
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    check_eq("ovf_fill_hold", {27'd0, fill_level}, 32'd16);
    hub_dwn        = 8'hEF;
    hub_dwn_valid  = 1'b1;
    clear_overflow = 1'b1;
    tick();
    hub_dwn_valid  = 1'b0;
    check_eq("ovf_set_wins", {31'd0, overflow}, 32'd1);
    tick();
    clear_overflow = 1'b0;
    check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);
    drain(16);
    check_eq("ovf_drained", {27'd0, fill_level}, 32'd0);
    ctrl_dwn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ovf_no_extra", {31'd0, ctrl_dwn_valid}, 32'd0);
    end
    ctrl_dwn_ready = 1'b0;
    tick();

    // Simultaneous write and emit at half full
    for (int i = 0; i < 8; i++) inject(8'h80 + 8'(i));
    check_eq("sim_fill8", {27'd0, fill_level}, 32'd8);
    ctrl_dwn_ready = 1'b1;
    hub_dwn        = 8'h99;
    hub_dwn_valid  = 1'b1;
    tick();
    hub_dwn_valid  = 1'b0;
    ctrl_dwn_ready = 1'b0;
    tmp = exp_q.pop_front();
    exp_q.push_back(8'h99);
    check_eq("sim_valid", {31'd0, ctrl_dwn_valid}, 32'd1);
    check_eq("sim_data", {24'd0, ctrl_dwn}, {24'd0, tmp});
    check_eq("sim_fill", {27'd0, fill_level}, 32'd8);
    tick();
    check_eq("sim_fill_after", {27'd0, fill_level}, 32'd8);
    drain(8);
    check_eq("sim_empty", {27'd0, fill_level}, 32'd0);

    // Pointer wrap: 40 bytes in rounds of 10
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) inject(8'h40 + 8'(r * 10 + i));
      check_eq("wrap_fill", {27'd0, fill_level}, 32'd10);
      drain(10);
    end
    check_eq("wrap_empty", {27'd0, fill_level}, 32'd0);

    // ce freeze with a pulse in flight, then mid-operation reset
    for (int i = 0; i < 5; i++) inject(8'hC0 + 8'(i));
    ctrl_dwn_ready = 1'b1;
    tick();
    tmp = exp_q.pop_front();
    check_eq("ce_pre_valid", {31'd0, ctrl_dwn_valid}, 32'd1);
    check_eq("ce_pre_data", {24'd0, ctrl_dwn}, {24'd0, tmp});
    ce             = 1'b0;
    hub_dwn        = 8'h55;
    hub_dwn_valid  = 1'b1;
    ctrl_dwn_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("ce_valid_hold", {31'd0, ctrl_dwn_valid}, 32'd1);
      check_eq("ce_fill_hold", {27'd0, fill_level}, 32'd4);
      check_eq("ce_data_hold", {24'd0, ctrl_dwn}, {24'd0, tmp});
    end
    ce             = 1'b1;
    hub_dwn_valid  = 1'b0;
    ctrl_dwn_ready = 1'b1;
    rst            = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_eq("mrst_fill", {27'd0, fill_level}, 32'd0);
    check_eq("mrst_valid", {31'd0, ctrl_dwn_valid}, 32'd0);
    check_eq("mrst_data", {24'd0, ctrl_dwn}, 32'h00);
    check_eq("mrst_ready", {31'd0, hub_dwn_ready}, 32'd1);
    ctrl_dwn_ready = 1'b0;
    tick();
    ctrl_dwn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mrst_no_stale", {31'd0, ctrl_dwn_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iurt_dwn_buffer.md
Name: iurt_dwn_buffer

Overview:
Byte FIFO between the JTAG hub's downstream byte channel and the IURT controller's receive input. It absorbs bursts from the hub, which delivers one-cycle valid pulses gated by a ready level. It releases bytes to the controller one at a time, as one-cycle valid pulses, only when the controller's receive-ready level is high. It also reports fill level and a sticky overflow flag.

Parameters:
ADDR_WIDTH, 4, log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH bytes (legal range 1..10).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
ce  input  1  clock enable; all state frozen when low.
hub_dwn_valid  input  1  one-cycle pulse per byte from the hub.
hub_dwn  input  8  byte from the hub, valid with hub_dwn_valid.
hub_dwn_ready  output  1  level; high while the FIFO is not full.
ctrl_dwn_ready  input  1  level from the controller; high when it can take a byte.
ctrl_dwn_valid  output  1  registered one-cycle pulse delivering ctrl_dwn.
ctrl_dwn  output  8  registered byte to the controller; holds its last value between pulses.
fill_level  output  ADDR_WIDTH+1  number of bytes stored (0..DEPTH).
overflow  output  1  sticky; a byte arrived while the FIFO was full.
clear_overflow  input  1  clears overflow (ce-gated).

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, holdoff=0, ctrl_dwn_valid=0, ctrl_dwn=8'h00, overflow=0. As a result hub_dwn_ready=1 and fill_level=0. Reset overrides ce and discards any operation in progress, including stored bytes.
- ce=0: no register changes, including ctrl_dwn_valid, which keeps its value. Inputs are ignored.
- Combinational outputs: hub_dwn_ready = (count != DEPTH); fill_level = count.
- Write: if ce & hub_dwn_valid & count != DEPTH, then mem[wr_ptr] <= hub_dwn and wr_ptr increments modulo DEPTH.
- Overflow: if ce & hub_dwn_valid & count == DEPTH, the byte is dropped, overflow <= 1, and pointers and count are unchanged. The full check uses the pre-edge count, so a same-cycle read does not make room for the write.
- Read/emit: if ce & count != 0 & ctrl_dwn_ready & ~holdoff, then:
  - ctrl_dwn <= mem[rd_ptr], ctrl_dwn_valid <= 1, rd_ptr increments modulo DEPTH, holdoff <= 1.
  - Otherwise, when ce is high, ctrl_dwn_valid <= 0.
- Holdoff: after each emit, no further emit until ctrl_dwn_ready has been sampled low (holdoff <= 0 on any ce cycle with ctrl_dwn_ready=0). This covers the controller keeping ready high for one cycle after the pulse. If ready never drops, no second emit occurs.
- Count: +1 on write only, -1 on emit only, unchanged on simultaneous write and emit or on neither. It never exceeds DEPTH and never goes below 0.
- Latency: a byte written into an empty FIFO at edge t appears as ctrl_dwn_valid=1 after edge t+1, provided ctrl_dwn_ready=1 and holdoff=0 in that cycle. Minimum latency is 2 cycles from the hub pulse to the output pulse.
- Ordering: strict FIFO; bytes are never duplicated or reordered.
- Overflow clear: if ce & clear_overflow, overflow <= 0. A set in the same cycle wins (overflow stays 1).
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap naturally. Full and empty are decided only by count.
- Memory has no reset; contents are undefined until written. ctrl_dwn is only updated from written locations.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then idle -> hub_dwn_ready=1, ctrl_dwn_valid=0, fill_level=0, overflow=0.
- Single byte: inject 8'hA5 with ctrl_dwn_ready=1 held -> ctrl_dwn_valid=1 for exactly one cycle, 2 cycles after injection, ctrl_dwn=8'hA5. No second pulse while ready stays high.
- Burst with controller model: inject 8'h01..8'h10 back-to-back (DEPTH=16). The controller drops ready the cycle after each pulse and raises it 3 cycles later -> bytes emerge in order 01..10, one pulse each. fill_level peaks at 15 or 16, then returns to 0.
- Overflow: ctrl_dwn_ready=0, inject 17 bytes (DEPTH=16) -> hub_dwn_ready=0 after the 16th byte, 17th byte dropped, overflow=1. Then assert clear_overflow with no write -> overflow=0. Drain yields the first 16 bytes only.
- Simultaneous write and emit with count=DEPTH/2 -> fill_level unchanged. Pointer wrap verified by pushing 40 bytes through DEPTH=16 with correct ordering.
- Mid-operation reset and ce: with 5 bytes stored, set ce=0 for 4 cycles -> no output change. Then assert rst for one cycle -> fill_level=0, ctrl_dwn_valid=0, and no stale byte is emitted afterwards.
